// File: rtl/audioplay_proce_cpu_div_cell_pkg.sv
// audioplay_proce_cpu_pkg: shared divider state encoding and constants
package audioplay_proce_cpu_pkg;
    localparam int DEF_DATA_W = 32;
    // Quotient bits are all set to this value on divide by zero
    localparam logic DZ_FILL = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/audioplay_proce_cpu_div_cell_if.sv
// audioplay_proce_cpu_div_cell_if: execute-side request and memory-side result bundle of the divider
interface audioplay_proce_cpu_div_cell_if
    import audioplay_proce_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] E_src1;
    logic [DATA_W-1:0] E_src2;
    logic              E_div_start;
    logic              E_div_signed;
    logic              M_div_flush;
    logic              M_div_busy;
    logic              M_div_done;
    logic [DATA_W-1:0] M_div_quot;
    logic [DATA_W-1:0] M_div_rem;
    logic              M_div_dz;
    modport master (
        output E_src1, E_src2, E_div_start, E_div_signed, M_div_flush,
        input  M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_dz
    );
    modport slave (
        input  E_src1, E_src2, E_div_start, E_div_signed, M_div_flush,
        output M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_dz
    );
endinterface

// File: rtl/audioplay_proce_cpu_div_step.sv
// audioplay_proce_cpu_div_step: one combinational restoring-division step
module audioplay_proce_cpu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-2:0] prem,
    input  logic              msb,
    input  logic [DATA_W-1:0] dvs,
    output logic [DATA_W-1:0] prem_n,
    output logic              qbit
);
    logic [DATA_W:0] trial;
    // The extra top bit is the borrow; set means the trial went negative
    assign trial  = {1'b0, prem, msb} - {1'b0, dvs};
    assign qbit   = ~trial[DATA_W];
    assign prem_n = qbit ? trial[DATA_W-1:0] : {prem, msb};
endmodule

// File: rtl/audioplay_proce_cpu_div_cell.sv
// audioplay_proce_cpu_div_cell: iterative restoring divider for div/divu, one quotient bit per cycle
module audioplay_proce_cpu_div_cell
    import audioplay_proce_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input logic clk,
    input logic reset,
    audioplay_proce_cpu_div_cell_if.slave div
);
    localparam int CW = $clog2(DATA_W);
    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] dvd, dvs, prem, prem_n, mag1, mag2;
    logic              qbit, sign1, sign2, neg_q, neg_r, dz_r;
    assign sign1 = div.E_div_signed & div.E_src1[DATA_W-1];
    assign sign2 = div.E_div_signed & div.E_src2[DATA_W-1];
    assign mag1  = sign1 ? -div.E_src1 : div.E_src1;
    assign mag2  = sign2 ? -div.E_src2 : div.E_src2;
    assign div.M_div_busy = state == CALC || state == FIX;
    assign div.M_div_done = state == DONE;
    audioplay_proce_cpu_div_step #(.DATA_W(DATA_W)) u_step (
        .prem   (prem[DATA_W-2:0]),
        .msb    (dvd[DATA_W-1]),
        .dvs    (dvs),
        .prem_n (prem_n),
        .qbit   (qbit)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = div.E_div_start ? CALC : IDLE;
            CALC:    state_n = div.M_div_flush ? IDLE : (cnt == '0 ? FIX : CALC);
            FIX:     state_n = div.M_div_flush ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // dvd doubles as the quotient: dividend bits leave at the top as quotient bits enter at the bottom
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            dvd            <= '0;
            dvs            <= '0;
            prem           <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            dz_r           <= 1'b0;
            div.M_div_quot <= '0;
            div.M_div_rem  <= '0;
            div.M_div_dz   <= 1'b0;
        end else begin
            if (state == IDLE && div.E_div_start) begin
                dvd   <= mag1;
                dvs   <= mag2;
                prem  <= '0;
                cnt   <= CW'(DATA_W - 1);
                neg_q <= sign1 ^ sign2;
                neg_r <= sign1;
                dz_r  <= div.E_src2 == '0;
            end
            if (state == CALC) begin
                prem <= prem_n;
                dvd  <= {dvd[DATA_W-2:0], qbit};
                cnt  <= cnt - 1'b1;
            end
            // With a zero divisor prem ends as |src1|, so the sign fix hands back the raw dividend
            if (state == FIX && !div.M_div_flush) begin
                div.M_div_quot <= dz_r ? {DATA_W{DZ_FILL}} : (neg_q ? -dvd : dvd);
                div.M_div_rem  <= neg_r ? -prem : prem;
                div.M_div_dz   <= dz_r;
            end
        end
    end
endmodule

// File: tb/tb_audioplay_proce_cpu_div_cell.sv
// tb_audioplay_proce_cpu_div_cell: scoreboard bench for the iterative divider
module tb_audioplay_proce_cpu_div_cell;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          due;
    } res_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0, total = 0, bad = 0, done_cnt = 0;
    res_t sbq[$];
    audioplay_proce_cpu_div_cell_if #(.DATA_W(32)) div();
    audioplay_proce_cpu_div_cell #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (div)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask
    task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s, input logic fl, output int t0);
        @(negedge clk);
        div.E_src1 = a;
        div.E_src2 = b;
        div.E_div_signed = s;
        div.E_div_start = 1'b1;
        div.M_div_flush = fl;
        t0 = cyc;
        @(negedge clk);
        div.E_div_start = 1'b0;
        div.M_div_flush = 1'b0;
    endtask
    task automatic push(input logic [31:0] q, input logic [31:0] r, input logic dz, input int t0);
        res_t e;
        e.q = q;
        e.r = r;
        e.dz = dz;
        e.due = t0 + 34;
        sbq.push_back(e);
    endtask
    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (div.M_div_done) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL done_timeout actual=none required=done");
    endtask
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [31:0] q, input logic [31:0] r, input logic dz);
        int t;
        go(a, b, s, 1'b0, t);
        push(q, r, dz, t);
        wait_done();
    endtask
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t m;
        int sa, sb;
        sa = a;
        sb = b;
        m.due = 0;
        m.dz = 1'b0;
        if (b == 0) begin
            m.q = 32'hFFFF_FFFF;
            m.r = a;
            m.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m.q = 32'h8000_0000;
            m.r = 0;
        end else if (s) begin
            m.q = sa / sb;
            m.r = sa % sb;
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction
    always @(negedge clk) begin : mon
        res_t e;
        if (!reset && div.M_div_done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=%h required=no_done", div.M_div_quot);
            end else begin
                e = sbq.pop_front();
                chk("quot", div.M_div_quot, e.q);
                chk("rem", div.M_div_rem, e.r);
                chk("dz", {31'b0, div.M_div_dz}, {31'b0, e.dz});
                chk("latency", cyc, e.due);
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
    initial begin
        int t, n0;
        logic [31:0] a, b;
        logic s;
        res_t m;
        div.E_src1 = 0;
        div.E_src2 = 0;
        div.E_div_start = 0;
        div.E_div_signed = 0;
        div.M_div_flush = 0;
        @(negedge clk);
        chk("rst_busy", {31'b0, div.M_div_busy}, 0);
        chk("rst_done", {31'b0, div.M_div_done}, 0);
        chk("rst_quot", div.M_div_quot, 0);
        chk("rst_rem", div.M_div_rem, 0);
        chk("rst_dz", {31'b0, div.M_div_dz}, 0);
        reset = 1'b0;
        go(100, 7, 1'b0, 1'b0, t);
        push(14, 2, 1'b0, t);
        for (int k = 1; k <= 33; k++) begin
            chk("busy_calc", {31'b0, div.M_div_busy}, 1);
            chk("done_early", {31'b0, div.M_div_done}, 0);
            @(negedge clk);
        end
        wait_done();
        chk("busy_at_done", {31'b0, div.M_div_busy}, 0);
        op(-32'sd7, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        op(7, -32'sd2, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1, 1, 1'b0);
        go(100, 7, 1'b0, 1'b0, t);
        push(14, 2, 1'b0, t);
        repeat (8) @(negedge clk);
        div.E_src1 = 9;
        div.E_src2 = 3;
        div.E_div_start = 1'b1;
        @(negedge clk);
        div.E_div_start = 1'b0;
        wait_done();
        op(9, 3, 1'b0, 3, 0, 1'b0);
        go(20, 6, 1'b0, 1'b1, t);
        push(3, 2, 1'b0, t);
        wait_done();
        op(5, 0, 1'b0, 32'hFFFF_FFFF, 5, 1'b1);
        op(5, 0, 1'b1, 32'hFFFF_FFFF, 5, 1'b1);
        go(1000, 10, 1'b0, 1'b0, t);
        repeat (13) @(negedge clk);
        div.M_div_flush = 1'b1;
        @(negedge clk);
        div.M_div_flush = 1'b0;
        chk("flush_busy", {31'b0, div.M_div_busy}, 0);
        n0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("flush_no_done", done_cnt, n0);
        chk("flush_quot", div.M_div_quot, 32'hFFFF_FFFF);
        chk("flush_rem", div.M_div_rem, 5);
        chk("flush_dz", {31'b0, div.M_div_dz}, 1);
        go(1000, 10, 1'b0, 1'b0, t);
        repeat (18) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, div.M_div_busy}, 0);
        chk("arst_quot", div.M_div_quot, 0);
        chk("arst_rem", div.M_div_rem, 0);
        chk("arst_dz", {31'b0, div.M_div_dz}, 0);
        @(negedge clk);
        reset = 1'b0;
        op(100, 7, 1'b0, 14, 2, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            a = (i % 97 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = -$urandom_range(1, 255);
                default: b = (i % 40 == 0) ? 0 : $urandom_range(1, 65535);
            endcase
            s = $urandom_range(0, 1);
            m = model(a, b, s);
            go(a, b, s, 1'b0, t);
            push(m.q, m.r, m.dz, t);
            wait_done();
        end
        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
